// File: rtl/i2c_master_sequencer.sv
// Single-byte I2C master: sequences an external MSB-first shift register and drives SCL/SDA.
// Define I2C_CLK_STRETCH_EN to pause SCL high phases while a slave holds SCL_in low.
module i2c_master_sequencer #(
  parameter int CLK_DIV = 125
) (
  input  logic       CLOCK,
  input  logic       Reset,
  input  logic       Go,
  input  logic       RW,
  input  logic [6:0] SlaveAddr,
  input  logic [7:0] WriteData,
  output logic [7:0] ReadData,
  output logic       Busy,
  output logic       Done,
  output logic       AckError,
  output logic       SCL,
  output logic       SDA_oe,
  input  logic       SDA_in,
  input  logic       SCL_in,
  output logic       WriteLoad,
  output logic       ShiftorHold,
  output logic [7:0] SentData,
  output logic       ShiftIn,
  input  logic       ShiftOut,
  input  logic [7:0] ReceivedData
);

  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    IDLE, START, LOADA, ABITS, AACK, LOADD, DBITS, DACK, STOP, DONE
  } state_e;

  state_e        stateQ, stateD;
  logic [DW-1:0] divQ, divD;
  logic [1:0]    qtrQ, qtrD;
  logic [2:0]    bitQ, bitD;
  logic          rwQ, rwD;
  logic [6:0]    addrQ, addrD;
  logic [7:0]    dataQ, dataD;
  logic          sampleQ, sampleD;
  logic          ackErrQ, ackErrD;
  logic [7:0]    readDataQ, readDataD;

  logic isBit, quartered, quarterEnd, lastQuarter, stretchHold;

  assign isBit       = (stateQ == ABITS) || (stateQ == AACK) || (stateQ == DBITS) || (stateQ == DACK);
  assign quartered   = isBit || (stateQ == START) || (stateQ == STOP);
  assign quarterEnd  = (divQ == DIV_LAST);
  assign lastQuarter = quarterEnd && (qtrQ == 2'd3);

  // SCL_in is expected to arrive already synchronised to CLOCK.
`ifdef I2C_CLK_STRETCH_EN
  assign stretchHold = ((isBit && qtrQ[1]) || ((stateQ == STOP) && (qtrQ == 2'd1)))
                       && (divQ == '0) && !SCL_in;
`else
  logic unusedSclIn;
  assign unusedSclIn = SCL_in;
  assign stretchHold = 1'b0;
`endif

  always_ff @(posedge CLOCK) begin
    if (Reset) begin
      stateQ    <= IDLE;
      divQ      <= '0;
      qtrQ      <= '0;
      bitQ      <= '0;
      rwQ       <= 1'b0;
      addrQ     <= '0;
      dataQ     <= '0;
      sampleQ   <= 1'b0;
      ackErrQ   <= 1'b0;
      readDataQ <= '0;
    end else begin
      stateQ    <= stateD;
      divQ      <= divD;
      qtrQ      <= qtrD;
      bitQ      <= bitD;
      rwQ       <= rwD;
      addrQ     <= addrD;
      dataQ     <= dataD;
      sampleQ   <= sampleD;
      ackErrQ   <= ackErrD;
      readDataQ <= readDataD;
    end
  end

  always_comb begin
    stateD      = stateQ;
    divD        = divQ;
    qtrD        = qtrQ;
    bitD        = bitQ;
    rwD         = rwQ;
    addrD       = addrQ;
    dataD       = dataQ;
    sampleD     = sampleQ;
    ackErrD     = ackErrQ;
    readDataD   = readDataQ;
    SCL         = 1'b1;
    SDA_oe      = 1'b0;
    WriteLoad   = 1'b0;
    ShiftorHold = 1'b0;
    SentData    = 8'h00;

    if (quartered && !stretchHold) begin
      if (quarterEnd) begin
        divD = '0;
        qtrD = qtrQ + 2'd1;
      end else begin
        divD = divQ + DW'(1);
      end
    end

    if (isBit && (qtrQ == 2'd2) && quarterEnd)
      sampleD = SDA_in;

    case (stateQ)
      IDLE: begin
        if (Go) begin
          rwD     = RW;
          addrD   = SlaveAddr;
          dataD   = WriteData;
          ackErrD = 1'b0;
          stateD  = START;
        end
      end
      START: begin
        SCL    = (qtrQ != 2'd3);
        SDA_oe = qtrQ[1];
        if (lastQuarter) stateD = LOADA;
      end
      LOADA: begin
        SCL       = 1'b0;
        SDA_oe    = 1'b1;
        WriteLoad = 1'b1;
        SentData  = {addrQ, rwQ};
        bitD      = '0;
        stateD    = ABITS;
      end
      ABITS: begin
        SCL    = qtrQ[1];
        SDA_oe = ~ShiftOut;
        if (lastQuarter) begin
          ShiftorHold = 1'b1;
          bitD        = bitQ + 3'd1;
          if (bitQ == 3'd7) stateD = AACK;
        end
      end
      AACK: begin
        SCL = qtrQ[1];
        if (lastQuarter) begin
          if (sampleQ) ackErrD = 1'b1;
          stateD = LOADD;
        end
      end
      // An address NACK still spends this slot so the fixed overhead stays at three cycles.
      LOADD: begin
        SCL = 1'b0;
        if (ackErrQ) begin
          stateD = STOP;
        end else begin
          WriteLoad = 1'b1;
          SentData  = rwQ ? 8'hFF : dataQ;
          bitD      = '0;
          stateD    = DBITS;
        end
      end
      DBITS: begin
        SCL    = qtrQ[1];
        SDA_oe = !rwQ && !ShiftOut;
        if (lastQuarter) begin
          ShiftorHold = 1'b1;
          bitD        = bitQ + 3'd1;
          if (bitQ == 3'd7) stateD = DACK;
        end
      end
      DACK: begin
        SCL = qtrQ[1];
        if (rwQ && (qtrQ == 2'd0) && (divQ == '0))
          readDataD = ReceivedData;
        if (lastQuarter) begin
          if (!rwQ && sampleQ) ackErrD = 1'b1;
          stateD = STOP;
        end
      end
      STOP: begin
        SCL    = (qtrQ != 2'd0);
        SDA_oe = !qtrQ[1];
        if (lastQuarter) stateD = DONE;
      end
      DONE: begin
        stateD = IDLE;
      end
      default: begin
        stateD = IDLE;
      end
    endcase
  end

  assign Busy     = (stateQ != IDLE) && (stateQ != DONE);
  assign Done     = (stateQ == DONE);
  assign AckError = ackErrQ;
  assign ReadData = readDataQ;
  assign ShiftIn  = sampleQ;

endmodule

// File: tb/tb_i2c_master_sequencer.sv
// Directed bench for i2c_master_sequencer: shift register model, I2C slave model, vector table.
module tb_i2c_master_sequencer;

  localparam int CLK_DIV = 4;
`ifdef I2C_CLK_STRETCH_EN
  localparam int STRETCH_CYC = 343;
`else
  localparam int STRETCH_CYC = 323;
`endif

  logic       CLOCK = 1'b0;
  logic       Reset = 1'b1;
  logic       Go = 1'b0;
  logic       RW = 1'b0;
  logic [6:0] SlaveAddr = '0;
  logic [7:0] WriteData = '0;
  logic [7:0] ReadData;
  logic       Busy, Done, AckError, SCL, SDA_oe, SDA_in, SCL_in;
  logic       WriteLoad, ShiftorHold, ShiftIn, ShiftOut;
  logic [7:0] SentData, ReceivedData;

  logic [7:0] srModel = 8'h00;
  logic       slaveLow = 1'b0;
  logic       stretchLow = 1'b0;

  i2c_master_sequencer #(.CLK_DIV(CLK_DIV)) dut (
    .CLOCK(CLOCK), .Reset(Reset), .Go(Go), .RW(RW), .SlaveAddr(SlaveAddr),
    .WriteData(WriteData), .ReadData(ReadData), .Busy(Busy), .Done(Done),
    .AckError(AckError), .SCL(SCL), .SDA_oe(SDA_oe), .SDA_in(SDA_in), .SCL_in(SCL_in),
    .WriteLoad(WriteLoad), .ShiftorHold(ShiftorHold), .SentData(SentData),
    .ShiftIn(ShiftIn), .ShiftOut(ShiftOut), .ReceivedData(ReceivedData)
  );

  always #5 CLOCK = ~CLOCK;

  assign SDA_in       = ~(SDA_oe | slaveLow);
  assign SCL_in       = SCL & ~stretchLow;
  assign ShiftOut     = srModel[7];
  assign ReceivedData = srModel;

  always @(posedge CLOCK) begin
    if (WriteLoad) srModel <= SentData;
    else if (ShiftorHold) srModel <= {srModel[6:0], ShiftIn};
  end

  logic       cfgRw = 1'b0, cfgAddrAck = 1'b1, cfgDataAck = 1'b1;
  logic [7:0] cfgSlaveByte = 8'h00;
  int         cfgStretchAt = 0;
  int         cfgStretchLen = 20;

  int   rises = 0, falls = 0, wlCount = 0, shCount = 0, overlapCount = 0, doneCount = 0;
  int   stretchLeft = 0;
  logic sdaLog [18];
  logic oeLog [18];
  logic sclPrev = 1'b1, busyPrev = 1'b0;

  // Bus observer and slave: counts SCL edges per transaction, logs each bit, answers ACK/data.
  always @(negedge CLOCK) begin
    if (Busy === 1'b1 && busyPrev === 1'b0) begin
      rises = 0; falls = 0; wlCount = 0; shCount = 0;
      slaveLow = 1'b0; stretchLow = 1'b0;
    end
    busyPrev = Busy;
    if (WriteLoad === 1'b1) wlCount++;
    if (ShiftorHold === 1'b1) shCount++;
    if (WriteLoad === 1'b1 && ShiftorHold === 1'b1) overlapCount++;
    if (Done === 1'b1) doneCount++;
    if (SCL === 1'b1 && sclPrev === 1'b0) begin
      if (rises < 18) begin
        sdaLog[rises] = SDA_in;
        oeLog[rises]  = SDA_oe;
      end
      rises++;
      if (cfgStretchAt != 0 && rises == cfgStretchAt) begin
        stretchLow  = 1'b1;
        stretchLeft = cfgStretchLen;
      end
    end else if (stretchLow) begin
      stretchLeft--;
      if (stretchLeft == 0) stretchLow = 1'b0;
    end
    if (SCL === 1'b0 && sclPrev === 1'b1) begin
      int idx;
      falls++;
      idx = falls - 1;
      if (idx == 8) slaveLow = cfgAddrAck;
      else if (cfgAddrAck && cfgRw && idx >= 9 && idx <= 16) slaveLow = ~cfgSlaveByte[16 - idx];
      else if (cfgAddrAck && !cfgRw && idx == 17) slaveLow = cfgDataAck;
      else slaveLow = 1'b0;
    end
    sclPrev = SCL;
  end

  typedef struct {
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       addrAck;
    logic       dataAck;
    logic [7:0] slaveByte;
    int         goAgainAt;
    logic [6:0] goAgainAddr;
    int         stretchAt;
    logic [7:0] expAddrLine;
    logic       expAckBit;
    logic       checkData;
    logic [7:0] expDataLine;
    logic       expAckErr;
    logic       checkRead;
    logic [7:0] expReadData;
    int         expCycles;
    int         expLoads;
    int         expShifts;
  } vec_t;

  vec_t tbl [7];
  int   testsRun = 0;
  int   failures = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v, output int cycles, output logic busyStart);
    cfgRw        = v.rw;
    cfgAddrAck   = v.addrAck;
    cfgDataAck   = v.dataAck;
    cfgSlaveByte = v.slaveByte;
    cfgStretchAt = v.stretchAt;
    @(negedge CLOCK);
    RW        = v.rw;
    SlaveAddr = v.addr;
    WriteData = v.wdata;
    Go        = 1'b1;
    @(negedge CLOCK);
    Go        = 1'b0;
    cycles    = 1;
    busyStart = Busy;
    while (Done !== 1'b1 && cycles < 2000) begin
      if (v.goAgainAt != 0 && cycles == v.goAgainAt) begin
        Go        = 1'b1;
        SlaveAddr = v.goAgainAddr;
      end else begin
        Go = 1'b0;
      end
      @(negedge CLOCK);
      cycles++;
    end
    Go = 1'b0;
  endtask

  task automatic runVector(input int i, input vec_t v);
    int         cycles;
    logic       busyStart;
    logic [7:0] addrLine, dataLine;
    applyStimulus(v, cycles, busyStart);
    for (int k = 0; k < 8; k++) begin
      addrLine[7-k] = sdaLog[k];
      dataLine[7-k] = sdaLog[9+k];
    end
    checkOutput($sformatf("v%0d done latency", i), cycles, v.expCycles);
    checkOutput($sformatf("v%0d busy after go", i), {31'd0, busyStart}, 32'd1);
    checkOutput($sformatf("v%0d ackerror", i), {31'd0, AckError}, {31'd0, v.expAckErr});
    checkOutput($sformatf("v%0d address on bus", i), {24'd0, addrLine}, {24'd0, v.expAddrLine});
    checkOutput($sformatf("v%0d address ack bit", i), {31'd0, sdaLog[8]}, {31'd0, v.expAckBit});
    checkOutput($sformatf("v%0d load strobes", i), wlCount, v.expLoads);
    checkOutput($sformatf("v%0d shift strobes", i), shCount, v.expShifts);
    if (v.checkData) begin
      checkOutput($sformatf("v%0d data on bus", i), {24'd0, dataLine}, {24'd0, v.expDataLine});
      checkOutput($sformatf("v%0d master sda at 9th data bit", i), {31'd0, oeLog[17]}, 32'd0);
    end
    if (v.checkRead)
      checkOutput($sformatf("v%0d readdata", i), {24'd0, ReadData}, {24'd0, v.expReadData});
    @(negedge CLOCK);
    checkOutput($sformatf("v%0d done width", i), {31'd0, Done}, 32'd0);
    repeat (5) @(negedge CLOCK);
    checkOutput($sformatf("v%0d idle after done", i), {31'd0, Busy}, 32'd0);
  endtask

  initial begin
    int waitCnt;
    int doneBefore;

    //           rw    addr   wdata  aAck  dAck  slave  goAt goAd  str | eAddr eAck  chkD  eData eErr  chkR  eRd    cyc          ld sh
    tbl[0] = '{1'b0, 7'h48, 8'hA5, 1'b1, 1'b1, 8'h00, 0,  7'h00, 0,  8'h90, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 323,         2, 16};
    tbl[1] = '{1'b1, 7'h48, 8'h00, 1'b1, 1'b1, 8'h3C, 0,  7'h00, 0,  8'h91, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 8'h3C, 323,         2, 16};
    tbl[2] = '{1'b0, 7'h48, 8'hA5, 1'b0, 1'b1, 8'h00, 0,  7'h00, 0,  8'h90, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 179,         1, 8};
    tbl[3] = '{1'b0, 7'h48, 8'h5A, 1'b1, 1'b0, 8'h00, 0,  7'h00, 0,  8'h90, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b0, 8'h00, 323,         2, 16};
    tbl[4] = '{1'b1, 7'h21, 8'h00, 1'b1, 1'b1, 8'hC3, 0,  7'h00, 0,  8'h43, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b1, 8'hC3, 323,         2, 16};
    tbl[5] = '{1'b0, 7'h48, 8'hA5, 1'b1, 1'b1, 8'h00, 50, 7'h21, 0,  8'h90, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 323,         2, 16};
    tbl[6] = '{1'b0, 7'h48, 8'hA5, 1'b1, 1'b1, 8'h00, 0,  7'h00, 10, 8'h90, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, STRETCH_CYC, 2, 16};

    repeat (3) @(negedge CLOCK);
    checkOutput("reset scl", {31'd0, SCL}, 32'd1);
    checkOutput("reset sda_oe", {31'd0, SDA_oe}, 32'd0);
    checkOutput("reset busy", {31'd0, Busy}, 32'd0);
    checkOutput("reset done", {31'd0, Done}, 32'd0);
    checkOutput("reset ackerror", {31'd0, AckError}, 32'd0);
    checkOutput("reset readdata", {24'd0, ReadData}, 32'd0);
    checkOutput("reset writeload", {31'd0, WriteLoad}, 32'd0);
    checkOutput("reset shift", {31'd0, ShiftorHold}, 32'd0);
    checkOutput("reset sentdata", {24'd0, SentData}, 32'd0);
    checkOutput("reset shiftin", {31'd0, ShiftIn}, 32'd0);
    Reset = 1'b0;
    repeat (2) @(negedge CLOCK);

    for (int i = 0; i < 7; i++) runVector(i, tbl[i]);

    // Reset during data bit 3 of a write: bus released at once, no STOP and no Done.
    cfgRw = 1'b0; cfgAddrAck = 1'b1; cfgDataAck = 1'b1; cfgStretchAt = 0;
    @(negedge CLOCK);
    RW = 1'b0; SlaveAddr = 7'h48; WriteData = 8'hA5; Go = 1'b1;
    @(negedge CLOCK);
    Go = 1'b0;
    waitCnt = 0;
    do begin
      @(negedge CLOCK);
      #1;
      waitCnt++;
    end while (falls != 13 && waitCnt < 1000);
    checkOutput("reach data bit 3", {31'd0, (falls == 13)}, 32'd1);
    doneBefore = doneCount;
    Reset = 1'b1;
    @(negedge CLOCK);
    checkOutput("midreset scl", {31'd0, SCL}, 32'd1);
    checkOutput("midreset sda_oe", {31'd0, SDA_oe}, 32'd0);
    checkOutput("midreset busy", {31'd0, Busy}, 32'd0);
    checkOutput("midreset done", {31'd0, Done}, 32'd0);
    Reset = 1'b0;
    repeat (400) @(negedge CLOCK);
    checkOutput("no done after reset", doneCount, doneBefore);
    runVector(100, tbl[0]);

    checkOutput("load and shift overlap", overlapCount, 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule
